lab6_sample_feeder: RTL and testbench

- Initiator and collector for the lab 6 datapath's irdy/din and ordy/dout handshake.
- Holds a small input-sample memory loaded by the host and, on start, presents each sample to the datapath.
- Holds each sample stable until the datapath's ordy rises, then captures dout into a result memory.
- Sits between the host/test logic and lab6dpath, replacing manual stimulus.

---
 rtl/lab6_sample_feeder.sv | 175 +++++++++++++++++
 tb/tb_lab6_sample_feeder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lab6_sample_feeder.sv
// Host-loaded sample memory that drives the lab 6 datapath irdy/din handshake and stores each dout.
// One sample per ISSUE + WAIT window; din stays stable until the ordy rising edge. A stalled datapath is abandoned after TIMEOUT WAIT cycles.
module lab6_sample_feeder #(
  parameter int W       = 10,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          start,
  input  logic [AW:0]   count,
  output logic          irdy,
  output logic [W-1:0]  din,
  input  logic          ordy,
  input  logic [W-1:0]  dout,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   n_done
);

  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   idx_nxt;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ordy_q, ordy_d;
  logic          irdy_q, irdy_d;
  logic [W-1:0]  din_q, din_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW:0]   n_done_q, n_done_d;

  logic [W-1:0]  in_mem  [DEPTH];
  logic [W-1:0]  res_mem [DEPTH];

  logic          rise;
  logic          in_we;
  logic          res_we;

  assign rise    = ordy & ~ordy_q;
  assign idx_nxt = idx_q + 1'b1;
  assign in_we   = wr_en & (state_q == S_IDLE) & ~reset;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    ordy_d   = ordy;
    irdy_d   = 1'b0;
    din_d    = din_q;
    done_d   = 1'b0;
    err_d    = err_q;
    n_done_d = n_done_q;
    res_we   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d    = (count > DEPTH_C) ? DEPTH_C : count;
          err_d    = 1'b0;
          n_done_d = '0;
          idx_d    = '0;
          if (cnt_d == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            irdy_d  = 1'b1;
            din_d   = in_mem[0];
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end

      S_WAIT: begin
        if (rise) begin
          res_we   = ~reset;
          n_done_d = n_done_q + 1'b1;
          idx_d    = idx_nxt;
          if (idx_nxt == cnt_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            // din is loaded together with irdy and then left alone for the whole window
            state_d = S_ISSUE;
            irdy_d  = 1'b1;
            din_d   = in_mem[idx_nxt[AW-1:0]];
          end
        end else if (tmo_q == TMO_MAX) begin
          err_d   = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      tmo_q    <= '0;
      ordy_q   <= 1'b0;
      irdy_q   <= 1'b0;
      din_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      n_done_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      ordy_q   <= ordy_d;
      irdy_q   <= irdy_d;
      din_q    <= din_d;
      done_q   <= done_d;
      err_q    <= err_d;
      n_done_q <= n_done_d;
    end
  end

  // Memories are deliberately left out of reset so results survive an aborted run
  always_ff @(posedge clk) begin
    if (in_we) begin
      in_mem[wr_addr] <= wr_data;
    end
    if (res_we) begin
      res_mem[idx_q[AW-1:0]] <= dout;
    end
  end

  assign irdy    = irdy_q;
  assign din     = din_q;
  assign done    = done_q;
  assign err     = err_q;
  assign n_done  = n_done_q;
  assign busy    = (state_q != S_IDLE);
  assign rd_data = res_mem[rd_addr];

endmodule

// File: tb/tb_lab6_sample_feeder.sv
// Bench for lab6_sample_feeder with a behavioural stand-in for the lab 6 datapath handshake.
module tb_lab6_sample_feeder;

  localparam int W       = 10;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          start;
  logic [AW:0]   count;
  logic          irdy;
  logic [W-1:0]  din;
  logic          ordy;
  logic [W-1:0]  dout;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   n_done;

  int vectors     = 0;
  int miscompares = 0;
  int gcyc        = 0;
  int last_irdy   = 0;
  int n_irdy      = 0;

  logic [W-1:0] mem_m [DEPTH];
  logic [W-1:0] res_m [DEPTH];
  bit           res_v [DEPTH];
  logic [W-1:0] q [$];

  always #5 clk = ~clk;

  lab6_sample_feeder #(.W(W), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .count(count), .irdy(irdy), .din(din), .ordy(ordy), .dout(dout),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
    .n_done(n_done)
  );

  // Stand-in datapath function: dout = 8 - (din >>> 1), two's complement, wrapping
  function automatic logic [W-1:0] dp_f(input logic [W-1:0] x);
    logic signed [W-1:0] h;
    h = $signed(x) >>> 1;
    return W'(10'sd8 - h);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Datapath model: drops ordy on the edge that samples irdy, raises it three edges later
  logic          ordy_m;
  logic [W-1:0]  dout_m = '0;
  logic [W-1:0]  x_m    = '0;
  logic [1:0]    ph_m   = 2'd0;
  logic          dp_dead = 1'b0;

  assign ordy = dp_dead ? 1'b0 : ordy_m;
  assign dout = dout_m;

  always @(posedge clk) begin
    gcyc <= gcyc + 1;
    if (reset) begin
      ordy_m <= 1'b1;
      ph_m   <= 2'd0;
    end else if (irdy) begin
      ordy_m <= 1'b0;
      ph_m   <= 2'd3;
      x_m    <= din;
    end else if (ph_m != 2'd0) begin
      ph_m <= ph_m - 2'd1;
      if (ph_m == 2'd1) begin
        ordy_m <= 1'b1;
        dout_m <= dp_f(x_m);
      end
    end
  end

  always @(negedge clk) begin
    if (irdy === 1'b1) begin
      if (n_irdy > 0) chk("irdy_gap", 32'(gcyc - last_irdy), 32'd5);
      last_irdy = gcyc;
      n_irdy++;
      if (q.size() == 0) chk("irdy_extra", 32'(irdy), 32'd0);
      else               chk("din_issue", 32'(din), 32'(q.pop_front()));
    end
    if (ph_m != 2'd0) chk("din_hold", 32'(din), 32'(x_m));
  end

  task automatic load(input int a, input logic [W-1:0] v);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = v;
    mem_m[a] = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_results();
    for (int i = 0; i < DEPTH; i++) begin
      if (res_v[i]) begin
        rd_addr = AW'(i);
        #1;
        chk("res_mem", 32'(rd_data), 32'(res_m[i]));
      end
    end
  endtask

  task automatic run(input int n, input int n_issue, input int exp_cyc, input int exp_n,
                     input logic exp_err, input int poke_cyc, input int rst_cyc);
    int cyc;
    bit seen;
    for (int i = 0; i < n_issue; i++) q.push_back(mem_m[i]);
    @(negedge clk);
    n_irdy = 0;
    start  = 1'b1;
    count  = (AW+1)'(n);
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      wr_en = 1'b0;
      if (cyc == poke_cyc) begin
        start   = 1'b1;
        count   = (AW+1)'(1);
        wr_en   = 1'b1;
        wr_addr = AW'(1);
        wr_data = 10'h155;
      end
      if (cyc == rst_cyc) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_irdy", 32'(irdy), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_n_done", 32'(n_done), 32'd0);
        q.delete();
        return;
      end
      if (done === 1'b1) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_cyc", 32'(cyc), 32'(exp_cyc));
    chk("done_busy", 32'(busy), 32'd1);
    chk("n_done", 32'(n_done), 32'(exp_n));
    chk("err", 32'(err), 32'(exp_err));
    chk("sb_empty", 32'(q.size()), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("err_hold", 32'(err), 32'(exp_err));
    chk("n_done_hold", 32'(n_done), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      res_m[i] = dp_f(mem_m[i]);
      res_v[i] = 1'b1;
    end
    check_results();
  endtask

  initial begin
    logic [W-1:0] full [DEPTH];
    full = '{10'h000, 10'h040, 10'h3C0, 10'h064, 10'h1FF, 10'h200, 10'h001, 10'h3FF};
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    count   = '0;
    rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) res_v[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_irdy", 32'(irdy), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_n_done", 32'(n_done), 32'd0);
    reset = 1'b0;

    load(0, 10'd64);
    run(1, 1, 6, 1, 1'b0, 0, 0);
    rd_addr = '0;
    #1;
    chk("res0_value", 32'(rd_data), 32'h3E8);

    for (int i = 0; i < DEPTH; i++) load(i, full[i]);
    run(8, 8, 41, 8, 1'b0, 0, 0);

    run(0, 0, 1, 0, 1'b0, 0, 0);
    run(12, 8, 41, 8, 1'b0, 0, 0);

    load(0, 10'h0AA);
    load(1, 10'h2F0);
    load(2, 10'h111);
    dp_dead = 1'b1;
    run(3, 1, TIMEOUT + 2, 0, 1'b1, 0, 0);
    dp_dead = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    chk("idle_after_tmo", 32'(busy), 32'd0);

    run(4, 4, 21, 4, 1'b0, 3, 0);
    run(8, 8, 0, 0, 1'b0, 0, 13);
    check_results();
    run(2, 2, 11, 2, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
